// File: rtl/key_highlight_if.sv
// Connects the keyboard decoder and frame timing to the highlight sequencer,
// and carries the highlight levels back out to the image renderer.
interface key_highlight_if;
  logic       key_valid;
  logic [2:0] key_code;
  logic       frame_tick;
  logic       clear;
  logic       aI;
  logic       bI;
  logic       cI;
  logic       dI;
  logic       upI;
  logic       downI;
  logic       leftI;
  logic       rightI;
  logic       busy;

  modport master (
    output key_valid, key_code, frame_tick, clear,
    input  aI, bI, cI, dI, upI, downI, leftI, rightI, busy
  );

  modport slave (
    input  key_valid, key_code, frame_tick, clear,
    output aI, bI, cI, dI, upI, downI, leftI, rightI, busy
  );
endinterface

// File: rtl/key_highlight_ctrl.sv
// Frame-synchronous keypad highlight sequencer: key events are collected during
// a frame and committed on frame_tick, then each highlight is held for HOLD_FRAMES frames.
module key_highlight_ctrl #(
  parameter int unsigned HOLD_FRAMES = 15,
  parameter int unsigned CNT_W       = 8
) (
  input logic           clk,
  input logic           reset,
  key_highlight_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [3:0]       r_pend,   w_pend_nxt;
  logic [CNT_W-1:0] r_cnt [4];
  logic [CNT_W-1:0] w_cnt_nxt [4];
  logic             r_apend,  w_apend_nxt;
  logic [1:0]       r_acode,  w_acode_nxt;
  logic [1:0]       r_aid,    w_aid_nxt;
  logic [CNT_W-1:0] r_acnt,   w_acnt_nxt;
  logic [3:0]       r_letter, w_letter_nxt;
  logic [3:0]       r_arrow,  w_arrow_nxt;
  logic             r_busy,   w_busy_nxt;

  logic             w_letter_key;
  logic             w_arrow_key;
  logic [3:0]       w_pend_eff;
  logic             w_apend_eff;
  logic [1:0]       w_acode_eff;

  assign w_letter_key = bus.key_valid & ~bus.key_code[2];
  assign w_arrow_key  = bus.key_valid &  bus.key_code[2];

  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    // A key arriving in the same cycle as frame_tick joins that commit.
    w_pend_eff = r_pend;
    if (w_letter_key) w_pend_eff[bus.key_code[1:0]] = 1'b1;
    w_apend_eff = r_apend | w_arrow_key;
    w_acode_eff = w_arrow_key ? bus.key_code[1:0] : r_acode;

    w_pend_nxt  = w_pend_eff;
    w_apend_nxt = w_apend_eff;
    w_acode_nxt = w_acode_eff;
    w_aid_nxt   = r_aid;
    w_acnt_nxt  = r_acnt;
    for (int i = 0; i < 4; i++) w_cnt_nxt[i] = r_cnt[i];

    if (bus.clear) begin
      w_pend_nxt  = '0;
      w_apend_nxt = 1'b0;
      w_acode_nxt = '0;
      w_aid_nxt   = '0;
      w_acnt_nxt  = '0;
      for (int i = 0; i < 4; i++) w_cnt_nxt[i] = '0;
    end else if (bus.frame_tick) begin
      w_pend_nxt  = '0;
      w_apend_nxt = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (w_pend_eff[i])        w_cnt_nxt[i] = HOLD;
        else if (r_cnt[i] != '0)  w_cnt_nxt[i] = r_cnt[i] - ONE;
      end
      if (w_apend_eff) begin
        w_aid_nxt  = w_acode_eff;
        w_acnt_nxt = HOLD;
      end else if (r_acnt != '0) begin
        w_acnt_nxt = r_acnt - ONE;
      end
    end

    // Outputs are registered from the next-state values so they move in the
    // same cycle as the counters rather than one cycle later.
    for (int i = 0; i < 4; i++) w_letter_nxt[i] = (w_cnt_nxt[i] != '0);
    w_arrow_nxt = (w_acnt_nxt != '0) ? (4'b0001 << w_aid_nxt) : 4'b0000;
    w_busy_nxt  = |{w_letter_nxt, w_arrow_nxt};
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values. The counter array is only four entries, so it is reset
  // like any other flop instead of being left to power-up contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend   <= '0;
      r_apend  <= 1'b0;
      r_acode  <= '0;
      r_aid    <= '0;
      r_acnt   <= '0;
      r_letter <= '0;
      r_arrow  <= '0;
      r_busy   <= 1'b0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_pend   <= w_pend_nxt;
      r_apend  <= w_apend_nxt;
      r_acode  <= w_acode_nxt;
      r_aid    <= w_aid_nxt;
      r_acnt   <= w_acnt_nxt;
      r_letter <= w_letter_nxt;
      r_arrow  <= w_arrow_nxt;
      r_busy   <= w_busy_nxt;
      for (int i = 0; i < 4; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign bus.aI     = r_letter[0];
  assign bus.bI     = r_letter[1];
  assign bus.cI     = r_letter[2];
  assign bus.dI     = r_letter[3];
  assign bus.upI    = r_arrow[0];
  assign bus.downI  = r_arrow[1];
  assign bus.leftI  = r_arrow[2];
  assign bus.rightI = r_arrow[3];
  assign bus.busy   = r_busy;

endmodule

// File: doc/key_highlight_ctrl.md
# key_highlight_ctrl

Sequencer for the keypad overlay on the VGA screen. It turns single-cycle key events from the keyboard decoder into frame-synchronous, timed highlight levels (`aI`..`dI`, `upI`..`rightI`) for the image ROM renderer. Highlights change only at frame boundaries, so a sprite never switches between its red/white or arrow variants mid-frame. It sits between the keyboard decoder and the image renderer, in the `clk` domain.

## Interface

Parameters:
- `HOLD_FRAMES`, default 15: number of frames a highlight stays on after commit. Legal range 1..255.
- `CNT_W`, default 8: width of each hold counter. Must satisfy `HOLD_FRAMES` < 2^`CNT_W`.

Ports:
- `clk` in 1: system clock (pixel-domain clock).
- `reset` in 1: asynchronous, active-low reset.
- `key_valid` in 1: single-cycle key event strobe.
- `key_code` in 3: key identity, sampled when `key_valid`=1. 0=A, 1=B, 2=C, 3=D, 4=up, 5=down, 6=left, 7=right.
- `frame_tick` in 1: one-cycle pulse at start of vertical blanking.
- `clear` in 1: synchronous clear of all highlights and pending events.
- `aI`, `bI`, `cI`, `dI` out 1 each: letter highlight levels.
- `upI`, `downI`, `leftI`, `rightI` out 1 each: arrow highlight levels. At most one is high at any time.
- `busy` out 1: OR of all eight highlight outputs.

## Operation

- **Letter slots (4).** Each slot has a `pend` flag and a hold counter `cnt` (`CNT_W` bits).
  - A `key_valid` with code 0..3 sets `pend` for that slot.
  - Several events to the same slot within one frame collapse into a single `pend`.
- **Arrow slot (1, shared).** Registers: `apend`, `acode[1:0]`, `aid[1:0]`, `acnt`.
  - A `key_valid` with code 4..7 sets `apend` and writes `acode` = `key_code`-4.
  - Latest arrow event in a frame wins.
- **Commit on `frame_tick`:**
  - Letter slot: if `pend`, then `cnt` <= `HOLD_FRAMES` (retrigger reloads); else if `cnt` != 0, then `cnt` <= `cnt`-1.
  - Clear all `pend` flags.
  - Arrow slot: if `apend`, then `aid` <= `acode` and `acnt` <= `HOLD_FRAMES` (a different arrow replaces the active one immediately); else if `acnt` != 0, then decrement it.
  - Clear `apend`.
- **Per-slot state (implicit FSM):**
  - IDLE: `cnt`=0, output low.
  - HELD: `cnt`>0, output high.
  - IDLE→HELD only on a commit with pending set.
  - HELD→IDLE on the tick that decrements 1→0.
- **Outputs:**
  - Letter output = registered (`cnt` != 0).
  - Arrow outputs = one-hot decode of `aid`, gated by (`acnt` != 0), registered.
  - Outputs change only on the cycle after a `frame_tick` or `clear`.
- **Simultaneous events:**
  - `key_valid` in the same cycle as `frame_tick` is included in that commit.
  - `key_valid` in the cycle after `frame_tick` waits for the next tick.
- **`clear`:**
  - Next cycle: all counters, `pend`, `apend`, `acode`, `aid` and outputs are 0.
  - `clear` overrides a coincident `frame_tick` and `key_valid`: neither has any effect.
- **Counter arithmetic:** a counter never decrements below 0 and never loads a value above `HOLD_FRAMES`. No wrap is possible.
- **`frame_tick` held high for multiple cycles:** each high cycle is a separate tick. This is the caller's responsibility; no edge detection is done.

## Timing

- **Reset (async assert, `reset`=0):** all outputs 0, `busy`=0, all counters, flags, `acode` and `aid` = 0.
- **Reset release:** synchronous to `clk`. The first rising edge with `reset`=1 may accept events.
- **Event latency:** committed at tick T (rising edge where `frame_tick`=1), output goes high after that edge (visible in cycle T+1).
- **Hold duration:**
  - Output is high after the commit at tick k.
  - Output drops after tick k+`HOLD_FRAMES`.
  - Exactly `HOLD_FRAMES` frame intervals high.
- **Retrigger:** an event committed at tick j while HELD makes the output stay high until after tick j+`HOLD_FRAMES`, with no glitch low.
- **`busy`:** same cycle as the outputs (registered OR, or OR of registered outputs). No additional latency.
- **Reset mid-hold:** outputs drop asynchronously. No state is retained; a tick after release finds all slots IDLE.

## Test plan

1. **Basic hold.** `HOLD_FRAMES`=3; key A at cycle 5, ticks every 20 cycles starting at 20. Required: `aI`=1 from cycle 21 through 80, `aI`=0 from cycle 81 (after the tick at 80); `busy` tracks `aI`.
2. **Arrow replacement.** Up committed at tick 1, left committed at tick 2. Required: after tick 2, `upI`=0 and `leftI`=1 in the same cycle; never both high; `leftI` drops after tick 5.
3. **Same-cycle and collapse.** `key_valid`(B) coincident with a tick, plus a second B in the same frame. Required: `bI` high the next cycle; hold is exactly 3 frames from that tick.
4. **Retrigger.** C committed at tick 1 and again at tick 3. Required: `cI` high continuously from after tick 1, low after tick 6.
5. **`clear` priority.** A HELD, `clear`, `frame_tick` and `key_valid`(D) all in one cycle. Required: all outputs 0 the next cycle; `dI` stays 0 after the following tick.
6. **Async reset.** `reset` driven low between clock edges during an up hold. Required: all outputs 0 immediately, before the next edge; after release plus one tick, all outputs still 0.
